// File: rtl/video_timing_gen_if.sv
// Video source bundle between video_timing_gen and the pixel pipe.
//
// Protocol: there is no backpressure. The source presents one pixel slot
// per clock; a slot carries a valid pixel exactly when out_blank is 0, and
// the sink must accept it on that clock. en/pattern_sel are controls
// driven by the sink side.
//
// Signals:
//   en           control  1   1 = run, 0 = hold at origin in blanking
//   pattern_sel  control  2   test pattern select
//   out_red/green/blue    8   pattern colour, 0 during blank
//   out_hsync/out_vsync   1   active-high syncs
//   out_blank             1   1 outside the active region
//   pix_x / pix_y      11/10  active pixel position, 0 during blank
//   frame_start           1   pulse with the pixel at (0,0)
//   frame_cnt             8   completed-frame counter
interface video_timing_gen_if;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [7:0]  out_red;
    logic [7:0]  out_green;
    logic [7:0]  out_blue;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_blank;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        input  en, pattern_sel,
        output out_red, out_green, out_blue, out_hsync, out_vsync,
               out_blank, pix_x, pix_y, frame_start, frame_cnt
    );

    modport slave (
        output en, pattern_sel,
        input  out_red, out_green, out_blue, out_hsync, out_vsync,
               out_blank, pix_x, pix_y, frame_start, frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: stand-alone 720p60 timing and test-pattern source.
//
// Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) walk the raster; every
// output is registered one clock after the counter state that produced it,
// so syncs, blank and RGB stay mutually aligned.
//
// Ports:
//   clk   in  pixel clock
//   rst   in  asynchronous, active-high reset
//   vif   video_timing_gen_if.master (en, pattern_sel in; video out)
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic               clk,
    input  logic               rst,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] BAR_W      = 11'd160;

    logic [10:0] h;
    logic [9:0]  v;
    logic [1:0]  pat_q;
    logic [7:0]  frame_cnt_q;

    logic        h_last;
    logic        v_last;
    logic        at_origin;
    logic        active;
    logic [1:0]  pat_eff;
    logic [2:0]  bar_code;
    logic [7:0]  red_c;
    logic [7:0]  green_c;
    logic [7:0]  blue_c;
    logic        hsync_c;
    logic        vsync_c;
    logic        blank_c;
    logic        fs_c;

    always_comb begin
        h_last    = (h == H_LAST);
        v_last    = (v == V_LAST);
        at_origin = (h == 11'd0) && (v == 10'd0);
        active    = (h < H_ACT_END) && (v < V_ACT_END);
        // The register loads at (0,0), so the origin pixel itself must
        // already use the newly selected pattern.
        pat_eff   = at_origin ? vif.pattern_sel : pat_q;
        // Bar index inverted so bar 0 is white; G follows the MSB, giving
        // white, yellow, cyan, green, magenta, red, blue, black.
        bar_code  = ~3'(h / BAR_W);
        red_c     = 8'h00;
        green_c   = 8'h00;
        blue_c    = 8'h00;
        if (active && vif.en) begin
            case (pat_eff)
                2'd0: begin
                    red_c   = {8{bar_code[1]}};
                    green_c = {8{bar_code[2]}};
                    blue_c  = {8{bar_code[0]}};
                end
                2'd1: begin
                    red_c   = h[10:3];
                    green_c = h[10:3];
                    blue_c  = h[10:3];
                end
                2'd2: begin
                    red_c   = v[9:2];
                    green_c = v[9:2];
                    blue_c  = v[9:2];
                end
                default: begin
                    red_c   = {8{h[6] ^ v[6]}};
                    green_c = {8{h[6] ^ v[6]}};
                    blue_c  = {8{h[6] ^ v[6]}};
                end
            endcase
        end
        // With en low everything collapses to the reset values.
        hsync_c = vif.en && (h >= H_SYNC_BEG) && (h < H_SYNC_END);
        vsync_c = vif.en && (v >= V_SYNC_BEG) && (v < V_SYNC_END);
        blank_c = !(vif.en && active);
        fs_c    = vif.en && at_origin;
    end

    // Raster counters, pattern register and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= 11'd0;
            v           <= 10'd0;
            pat_q       <= 2'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            if (at_origin) begin
                pat_q <= vif.pattern_sel;
            end
            if (!vif.en) begin
                h <= 11'd0;
                v <= 10'd0;
            end else if (h_last) begin
                h <= 11'd0;
                if (v_last) begin
                    v           <= 10'd0;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end else begin
                    v <= v + 10'd1;
                end
            end else begin
                h <= h + 11'd1;
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vif.out_red     <= 8'h00;
            vif.out_green   <= 8'h00;
            vif.out_blue    <= 8'h00;
            vif.out_hsync   <= 1'b0;
            vif.out_vsync   <= 1'b0;
            vif.out_blank   <= 1'b1;
            vif.pix_x       <= 11'd0;
            vif.pix_y       <= 10'd0;
            vif.frame_start <= 1'b0;
        end else begin
            vif.out_red     <= red_c;
            vif.out_green   <= green_c;
            vif.out_blue    <= blue_c;
            vif.out_hsync   <= hsync_c;
            vif.out_vsync   <= vsync_c;
            vif.out_blank   <= blank_c;
            vif.pix_x       <= blank_c ? 11'd0 : h;
            vif.pix_y       <= blank_c ? 10'd0 : v;
            vif.frame_start <= fs_c;
        end
    end

    assign vif.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a shortened vertical and porch timing
// (full 1280-pixel lines) so several whole frames fit in a short run.
module tb_video_timing_gen;
  localparam int HA = 1280;
  localparam int HF = 10;
  localparam int HS = 4;
  localparam int HB = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int W = 45;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_timing_gen_if vif();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: {y[9:0], x[10:0], rgb[23:0]}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] head;

  task automatic push_pix(input int x, input int y, input logic [23:0] rgb);
    exp_q.push_back({10'(y), 11'(x), rgb});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && !vif.out_blank) begin
      head = exp_q[0];
      if (vif.pix_x == head[34:24] && vif.pix_y == head[44:35]) begin
        check($sformatf("pix(%0d,%0d)", head[34:24], head[44:35]),
              {vif.out_red, vif.out_green, vif.out_blue}, head[23:0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // timing monitor over the first two complete frames
  int cyc = 0;
  int fs_num = 0;
  int act_cnt = 0;
  int fs_cyc = 0;
  int hs_rise_cyc = 0;
  int vs_rise_cyc = 0;
  int hs_cnt = 0;
  bit have_hs = 0;
  bit have_vs = 0;
  bit line0 = 0;
  logic prev_hs = 1'b0;
  logic prev_vs = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (fs_num < 3) begin
      if (vif.frame_start) begin
        if (fs_num > 0) check("active_clks", act_cnt, VA * HA);
        check($sformatf("frame_cnt@fs%0d", fs_num), vif.frame_cnt, fs_num);
        fs_num++;
        act_cnt = 1;
        fs_cyc = cyc;
        line0 = 1;
      end else if (!vif.out_blank) begin
        act_cnt++;
      end
      if (vif.out_hsync && !prev_hs) begin
        if (have_hs) check("hsync_period", cyc - hs_rise_cyc, HT);
        if (line0) check("first_hsync_offset", cyc - fs_cyc, HA + HF);
        line0 = 0;
        have_hs = 1;
        hs_rise_cyc = cyc;
        hs_cnt++;
      end
      if (!vif.out_hsync && prev_hs) check("hsync_width", cyc - hs_rise_cyc, HS);
      if (vif.out_vsync && !prev_vs) begin
        if (have_vs) check("hsyncs_per_frame", hs_cnt, VT);
        check("vsync_at_line_start", cyc - hs_rise_cyc, HS + HB);
        have_vs = 1;
        hs_cnt = 0;
        vs_rise_cyc = cyc;
      end
      if (!vif.out_vsync && prev_vs) check("vsync_width", cyc - vs_rise_cyc, VS * HT);
    end
    prev_hs = vif.out_hsync;
    prev_vs = vif.out_vsync;
  end

  // driver tasks
  task automatic wait_pix(input int x, input int y, input int budget);
    bit found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      found = !vif.out_blank && vif.pix_x == 11'(x) && vif.pix_y == 10'(y);
    end
    check($sformatf("reach(%0d,%0d)", x, y), found, 1);
  endtask

  task automatic wait_fs(input int budget);
    bit found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      found = vif.frame_start;
    end
    check("reach_frame_start", found, 1);
  endtask

  task automatic check_idle(input string tag, input logic [7:0] fc);
    check({tag, "_blank"}, vif.out_blank, 1);
    check({tag, "_hsync"}, vif.out_hsync, 0);
    check({tag, "_vsync"}, vif.out_vsync, 0);
    check({tag, "_rgb"}, {vif.out_red, vif.out_green, vif.out_blue}, 0);
    check({tag, "_pix_x"}, vif.pix_x, 0);
    check({tag, "_pix_y"}, vif.pix_y, 0);
    check({tag, "_frame_start"}, vif.frame_start, 0);
    check({tag, "_frame_cnt"}, vif.frame_cnt, fc);
  endtask

  task automatic check_origin(input string tag);
    check({tag, "_frame_start"}, vif.frame_start, 1);
    check({tag, "_blank"}, vif.out_blank, 0);
    check({tag, "_pix_x"}, vif.pix_x, 0);
    check({tag, "_pix_y"}, vif.pix_y, 0);
  endtask

  int bad;

  initial begin
    vif.en = 1'b1;
    vif.pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    check_idle("reset", 8'd0);

    // frame 0: colour bars; switched to horizontal ramp at line 2
    push_pix(0, 0, 24'hFFFFFF);
    push_pix(160, 0, 24'hFFFF00);
    push_pix(159, 1, 24'hFFFFFF);
    push_pix(1279, 1, 24'h000000);
    push_pix(961, 4, 24'h0000FF);
    push_pix(1279, 5, 24'h000000);
    rst = 1'b0;
    @(negedge clk);
    check_origin("first");

    wait_pix(0, 2, FRAME);
    vif.pattern_sel = 2'd1;
    push_pix(0, 0, 24'h000000);
    push_pix(8, 0, 24'h010101);
    push_pix(1279, 0, 24'h9F9F9F);
    push_pix(1024, 3, 24'h808080);
    push_pix(1279, 5, 24'h9F9F9F);

    // frame 1: switch to vertical ramp at line 3
    wait_fs(FRAME + 10);
    wait_pix(0, 3, FRAME);
    vif.pattern_sel = 2'd2;
    push_pix(1000, 0, 24'h000000);
    push_pix(1000, 3, 24'h000000);
    push_pix(1000, 4, 24'h010101);
    push_pix(5, 5, 24'h010101);

    // frame 2: switch to checkerboard at line 1
    wait_fs(FRAME + 10);
    wait_pix(0, 1, FRAME);
    vif.pattern_sel = 2'd3;
    push_pix(0, 0, 24'h000000);
    push_pix(64, 0, 24'hFFFFFF);
    push_pix(127, 0, 24'hFFFFFF);
    push_pix(128, 1, 24'h000000);
    push_pix(200, 1, 24'hFFFFFF);

    // frame 3: drop en mid-frame for 1000 clocks
    wait_fs(FRAME + 10);
    check("frame_cnt_f3", vif.frame_cnt, 3);
    wait_pix(500, 2, FRAME);
    vif.en = 1'b0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (vif.out_blank !== 1'b1 || vif.out_hsync !== 1'b0 || vif.out_vsync !== 1'b0 ||
          {vif.out_red, vif.out_green, vif.out_blue} !== 24'h0 || vif.frame_start !== 1'b0 ||
          vif.pix_x !== 11'd0 || vif.pix_y !== 10'd0)
        bad++;
    end
    check("en_low_bad_clks", bad, 0);
    check("en_low_frame_cnt", vif.frame_cnt, 3);
    vif.en = 1'b1;
    @(negedge clk);
    check_origin("en_rise");
    check("en_rise_frame_cnt", vif.frame_cnt, 3);

    // async reset mid-line, then restart
    wait_pix(699, 3, FRAME);
    rst = 1'b1;
    #1;
    check_idle("async_rst", 8'd0);
    repeat (2) @(negedge clk);
    push_pix(128, 0, 24'h000000);
    push_pix(200, 0, 24'hFFFFFF);
    rst = 1'b0;
    @(negedge clk);
    check_origin("rst_release");
    wait_pix(200, 0, HT);
    repeat (20) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    check("timing_frames_seen", fs_num, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
